// File: rtl/sega_pad_responder.sv
// sega_pad_responder: pad-side end of the Sega joystick protocol.
// Watches SELECT from the console and drives D0..D5 the way a 3- or
// 6-button pad does, walking the 8-phase 6-button sequence on SELECT edges
// and restarting at phase 0/1 after TIMEOUT_CYCLES without an edge.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   sel_i        SELECT from the connector (asynchronous to clk)
//   btn_i[11:0]  pressed = 1: Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode
//   d_o[5:0]     pad data lines, active-low, registered
//   frame_done_o one-cycle pulse after the phase wraps 7 -> 0 on an edge
module sega_pad_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 21000,
    parameter bit          SIX_BUTTON     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic [11:0] btn_i,
    output logic [5:0]  d_o,
    output logic        frame_done_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PH_W  = 3;

    logic             sel_meta;
    logic             sel_sync;
    logic             sel_prev;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_nxt;
    logic [PH_W-1:0]  out_phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [5:0]       d_nxt;
    logic             frame_done_nxt;
    logic             sel_edge_c;

    logic up, down, left, right, btn_a, btn_b, btn_c, start, btn_x, btn_y, btn_z, mode;

    assign {mode, btn_z, btn_y, btn_x, start, btn_c, btn_b, btn_a,
            right, left, down, up} = btn_i;

    assign sel_edge_c = sel_sync ^ sel_prev;

    // SELECT synchronizer; idles high so a low SELECT after reset is seen as a fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_meta <= 1'b1;
            sel_sync <= 1'b1;
            sel_prev <= 1'b1;
        end else begin
            sel_meta <= sel_i;
            sel_sync <= sel_meta;
            sel_prev <= sel_sync;
        end
    end

    // Phase / timeout state register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase        <= '0;
            cnt          <= '0;
            d_o          <= 6'h3F;
            frame_done_o <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            cnt          <= cnt_nxt;
            d_o          <= d_nxt;
            frame_done_o <= frame_done_nxt;
        end
    end

    // Next phase: an edge always advances (and beats a coincident timeout);
    // the timeout re-aligns phase to the SELECT level while saturated.
    always_comb begin
        phase_nxt      = phase;
        cnt_nxt        = cnt;
        frame_done_nxt = 1'b0;
        if (sel_edge_c) begin
            phase_nxt      = phase + PH_W'(1);
            cnt_nxt        = '0;
            frame_done_nxt = SIX_BUTTON && (phase == PH_W'(7));
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            phase_nxt = sel_sync ? PH_W'(0) : PH_W'(1);
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Data-line mapping; a 3-button pad only looks at the SELECT level
    always_comb begin
        out_phase = SIX_BUTTON ? phase : {2'b00, phase[0]};
        case (out_phase)
            3'd1, 3'd3: d_nxt = {~start, ~btn_a, 2'b00, ~down, ~up};
            3'd5:       d_nxt = {~start, ~btn_a, 4'b0000};
            3'd6:       d_nxt = {~btn_c, ~btn_b, ~mode, ~btn_x, ~btn_y, ~btn_z};
            3'd7:       d_nxt = {~start, ~btn_a, 4'b1111};
            default:    d_nxt = {~btn_c, ~btn_b, ~right, ~left, ~down, ~up};
        endcase
    end

endmodule

// File: tb/tb_sega_pad_responder.sv
// Bench for sega_pad_responder: a 6-button and a 3-button instance share
// clk/reset/SELECT/buttons and are checked against hand-computed patterns.
module tb_sega_pad_responder;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [11:0] btn;
    logic [5:0]  d6;
    logic [5:0]  d3;
    logic        fd6;
    logic        fd3;

    int n_cmp;
    int n_bad;
    int fd6_cnt;
    int fd3_cnt;

    typedef struct {
        logic        sel;
        logic [11:0] btn;
        int          wait_cyc;
        logic [5:0]  exp6;
        logic [5:0]  exp3;
        int          exp_fd6;
    } vec_t;

    vec_t vecs[$];

    sega_pad_responder #(.TIMEOUT_CYCLES(64), .SIX_BUTTON(1'b1)) dut6 (
        .clk(clk), .reset(reset), .sel_i(sel), .btn_i(btn),
        .d_o(d6), .frame_done_o(fd6)
    );

    sega_pad_responder #(.TIMEOUT_CYCLES(64), .SIX_BUTTON(1'b0)) dut3 (
        .clk(clk), .reset(reset), .sel_i(sel), .btn_i(btn),
        .d_o(d3), .frame_done_o(fd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses just after each active edge
    always begin
        @(posedge clk);
        #1;
        if (fd6) fd6_cnt++;
        if (fd3) fd3_cnt++;
    end

    task automatic check6(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 6'h%02h, expected 6'h%02h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        fd6_cnt = 0;
        fd3_cnt = 0;
        reset   = 1'b1;
        sel     = 1'b1;
        btn     = 12'h000;

        // Frame A: everything pressed
        vecs.push_back('{1'b1, 12'hFFF,  2, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b0, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b1, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b0, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b1, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b0, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b1, 12'hFFF, 10, 6'h00, 6'h00, 0});
        vecs.push_back('{1'b0, 12'hFFF, 10, 6'h0F, 6'h00, 0});
        vecs.push_back('{1'b1, 12'hFFF, 10, 6'h00, 6'h00, 1});
        // Frame B: nothing pressed
        vecs.push_back('{1'b1, 12'h000,  2, 6'h3F, 6'h3F, 1});
        vecs.push_back('{1'b0, 12'h000, 10, 6'h33, 6'h33, 1});
        vecs.push_back('{1'b1, 12'h000, 10, 6'h3F, 6'h3F, 1});
        vecs.push_back('{1'b0, 12'h000, 10, 6'h33, 6'h33, 1});
        vecs.push_back('{1'b1, 12'h000, 10, 6'h3F, 6'h3F, 1});
        vecs.push_back('{1'b0, 12'h000, 10, 6'h30, 6'h33, 1});
        vecs.push_back('{1'b1, 12'h000, 10, 6'h3F, 6'h3F, 1});
        vecs.push_back('{1'b0, 12'h000, 10, 6'h3F, 6'h33, 1});
        vecs.push_back('{1'b1, 12'h000, 10, 6'h3F, 6'h3F, 2});
        // Frame C: mixed buttons, individual X/Y/Z/Mode in phase 6
        vecs.push_back('{1'b1, 12'hA5A,  2, 6'h15, 6'h15, 2});
        vecs.push_back('{1'b0, 12'hA5A, 10, 6'h21, 6'h21, 2});
        vecs.push_back('{1'b1, 12'hA5A, 10, 6'h15, 6'h15, 2});
        vecs.push_back('{1'b0, 12'hA5A, 10, 6'h21, 6'h21, 2});
        vecs.push_back('{1'b1, 12'hA5A, 10, 6'h15, 6'h15, 2});
        vecs.push_back('{1'b0, 12'hA5A, 10, 6'h20, 6'h21, 2});
        vecs.push_back('{1'b1, 12'h400, 10, 6'h3E, 6'h3F, 2});
        vecs.push_back('{1'b1, 12'h800,  2, 6'h37, 6'h3F, 2});
        vecs.push_back('{1'b1, 12'h200,  2, 6'h3D, 6'h3F, 2});
        vecs.push_back('{1'b1, 12'h100,  2, 6'h3B, 6'h3F, 2});
        vecs.push_back('{1'b0, 12'hA5A, 10, 6'h2F, 6'h21, 2});
        vecs.push_back('{1'b1, 12'h000, 10, 6'h3F, 6'h3F, 3});

        // Reset state
        cycles(3);
        check6("reset_d6", d6, 6'h3F);
        check6("reset_d3", d3, 6'h3F);
        check_int("reset_fd6", int'(fd6), 0);
        reset = 1'b0;
        cycles(1);
        check6("post_reset_d6", d6, 6'h3F);

        // Up + C, one-cycle button latency
        btn = 12'h041;
        cycles(1);
        check6("upc_d6", d6, 6'h1E);
        check6("upc_d3", d3, 6'h1E);

        // Table-driven frames
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            btn = vecs[i].btn;
            cycles(vecs[i].wait_cyc);
            check6($sformatf("vec%0d_d6", i), d6, vecs[i].exp6);
            check6($sformatf("vec%0d_d3", i), d3, vecs[i].exp3);
            check_int($sformatf("vec%0d_fd6", i), fd6_cnt, vecs[i].exp_fd6);
            check_int($sformatf("vec%0d_fd3", i), fd3_cnt, 0);
        end

        // SELECT-to-data latency is four clocks
        btn = 12'h000;
        sel = 1'b0;
        cycles(3);
        check6("lat3_d6", d6, 6'h3F);
        cycles(1);
        check6("lat4_d6", d6, 6'h33);
        check6("lat4_d3", d3, 6'h33);
        cycles(6);

        // Reach phase 3 with SELECT low, then let the timeout expire
        sel = 1'b1;
        cycles(10);
        sel = 1'b0;
        cycles(10);
        cycles(80);
        check6("to_hold_d6", d6, 6'h33);
        check_int("to_no_frame", fd6_cnt, 3);
        sel = 1'b1;
        cycles(10);
        check6("to_rise_d6", d6, 6'h3F);
        sel = 1'b0;
        cycles(10);
        check6("to_restart_d6", d6, 6'h33);
        check6("to_restart_d3", d3, 6'h33);

        // A gap shorter than the timeout keeps the sequence going (3 -> 4 -> 5)
        cycles(40);
        sel = 1'b1;
        cycles(10);
        check6("no_to_ph4_d6", d6, 6'h3F);
        sel = 1'b0;
        cycles(10);
        check6("no_to_ph5_d6", d6, 6'h30);
        check6("no_to_ph5_d3", d3, 6'h33);

        // Phase 6, then reset mid-sequence
        btn = 12'h400;
        sel = 1'b1;
        cycles(10);
        check6("pre_rst_ph6_d6", d6, 6'h3E);
        reset = 1'b1;
        sel   = 1'b0;
        btn   = 12'h000;
        #1;
        check6("async_rst_d6", d6, 6'h3F);
        check_int("async_rst_fd6", int'(fd6), 0);
        cycles(2);
        reset = 1'b0;
        cycles(3);
        check6("rst_rel3_d6", d6, 6'h3F);
        cycles(1);
        check6("rst_rel4_d6", d6, 6'h33);

        // Counting restarted from 0: four more edges land on phase 5
        for (int k = 0; k < 4; k++) begin
            sel = ~sel;
            cycles(10);
        end
        check6("rst_ph5_d6", d6, 6'h30);
        check6("rst_ph5_d3", d3, 6'h33);
        check_int("final_fd6", fd6_cnt, 3);
        check_int("final_fd3", fd3_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
